// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
// Bits are processed LSB first through one full-subtractor cell per clock.
// Operands enter and results leave over valid/ready handshakes.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf
// and the storage for the operand sign bits it needs.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // r_a doubles as the result shift register: minuend bits leave at the LSB
  // while difference bits enter at the MSB, so after WIDTH shifts it holds diff.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_borrow_next;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_final;

  assign w_a0          = r_a[0];
  assign w_b0          = r_b[0];
  assign w_d           = w_a0 ^ w_b0 ^ r_borrow;
  assign w_borrow_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
  assign w_last        = (r_cnt == CNT_LAST);
  // Complete result as it will look once the final bit has been shifted in.
  assign w_diff_final  = {w_d, r_a[WIDTH-1:1]};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;

  // State register; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept in IDLE, shift WIDTH cycles, hold result until drained.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Serial datapath: latch operands on accept, then one subtractor step per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          r_a      <= w_diff_final;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrow_next;
          r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Result registers: loaded only on the final bit, so they stay put through
  // DONE and after the drain until the next result replaces them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (r_state == S_BUSY && w_last) begin
      r_diff <= w_diff_final;
      r_bout <= w_borrow_next;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of r_a/r_b, so keep copies for overflow.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Sign-bit capture on accept and overflow flag registered alongside diff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      if (r_state == S_BUSY && w_last) begin
        r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv,
                                             input logic binv);
    int          r;
    logic [31:0] rv;
    logic        borrow;
    r      = int'(av) - int'(bv) - int'(binv);
    rv     = r;
    borrow = (int'(av) < int'(bv) + int'(binv));
    return {borrow, rv[WIDTH-1:0]};
  endfunction

  // One full operation; stall = cycles out_ready stays low in DONE,
  // noise = drive junk in_valid/operands while busy or holding.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic binv,
                        input int stall, input bit noise);
    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
    int               n;
    int               lat;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
    a = av; b = bv; bin = binv; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    e        = ref_sub(av, bv, binv);
    exp_diff = e[WIDTH-1:0];
    exp_bout = e[WIDTH];
    if (noise) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    chk({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(WIDTH));
    chk({tag, ":in_ready_done"}, 64'(in_ready), 64'd0);
    chk({tag, ":diff"}, 64'(diff), 64'(exp_diff));
    chk({tag, ":bout"}, 64'(bout), 64'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ":ovf"}, 64'(ovf),
        64'((av[WIDTH-1] != bv[WIDTH-1]) && (exp_diff[WIDTH-1] != av[WIDTH-1])));
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ":hold_diff"}, {63'd0, bout, diff}, {63'd0, exp_bout, exp_diff});
      chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":drained"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    chk({tag, ":diff_kept"}, 64'(diff), 64'(exp_diff));
    $display("op %s a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d lat=%0d stall=%0d",
             tag, av, bv, binv, diff, bout, lat, stall);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("reset_outputs", {60'd0, out_valid, in_ready, bout, 1'b0}, {60'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("reset_diff", 64'(diff), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op("t1", 8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    chk("t1_value", {63'd0, bout, diff}, {63'd0, 1'b0, 8'h1E});
    run_op("t2", 8'h3C, 8'h5A, 1'b1, 0, 1'b0);
    chk("t2_value", {63'd0, bout, diff}, {63'd0, 1'b1, 8'hE1});
    run_op("t3", 8'h00, 8'h01, 1'b0, 0, 1'b0);
    chk("t3_value", {63'd0, bout, diff}, {63'd0, 1'b1, 8'hFF});
    run_op("t3_ovf", 8'h80, 8'h01, 1'b0, 0, 1'b0);
    chk("t3_ovf_value", 64'(diff), 64'h7F);
    run_op("eq", 8'hA7, 8'hA7, 1'b0, 1, 1'b0);
    chk("eq_value", {63'd0, bout, diff}, {63'd0, 1'b0, 8'h00});
    run_op("zero_bin", 8'h00, 8'h00, 1'b1, 0, 1'b0);
    chk("zero_bin_value", {63'd0, bout, diff}, {63'd0, 1'b1, 8'hFF});
    run_op("t4_stall", 8'hC3, 8'h47, 1'b1, 5, 1'b1);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("t5_rst_ctrl", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    chk("t5_rst_data", {63'd0, bout, diff}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("t5_after", 8'h10, 8'h01, 1'b0, 0, 1'b0);
    chk("t5_after_value", 64'(diff), 64'h0F);

    // Randomized operations with random back-pressure and input noise.
    for (int i = 0; i < 200; i++) begin
      run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom),
             1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
